// File: rtl/inst_mem_server_if.sv
// Fetch handshake between the core fetch stage (master) and the instruction memory server (slave).
`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif

interface inst_mem_server_if;
    logic [`LEN_MEM_ADDR-1:0] pc;
    logic                     order;
    logic [`LEN_INST-1:0]     inst;
    logic                     fetched;
    logic                     busy;

    modport master (output pc, output order, input inst, input fetched, input busy);
    modport slave  (input pc, input order, output inst, output fetched, output busy);
endinterface

// File: rtl/inst_mem_server.sv
// Instruction memory server: answers fetch orders from a synchronous-read RAM
// that the boot loader fills sequentially through the loader port.
//
// state  | meaning
// IDLE   | waiting for an order (refused while load_en=1)
// READ   | RAM read in flight, output register settles
// WAIT   | extra response delay, down-counter to zero
// RESP   | fetched pulse cycle, inst holds the answer
module inst_mem_server #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_server_if.slave     fetch,
    output logic                 misalign,
    output logic                 overlap_err,
    input  logic                 load_en,
    input  logic                 load_we,
    input  logic [`LEN_INST-1:0] load_data,
    output logic [ADDR_W:0]      load_cnt,
    output logic                 load_ovf
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           state;
    logic [3:0]           wait_cnt;
    logic                 bad_q;
    logic                 load_en_q;
    logic [`LEN_INST-1:0] mem [2**ADDR_W];
    logic [`LEN_INST-1:0] rdata;

    logic              pc_misalign;
    logic              pc_range;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              accept;
    logic              load_rise;
    logic              wr_full;
    logic              go_resp;

    assign pc_misalign = |fetch.pc[1:0];
    assign pc_range    = |(fetch.pc >> (ADDR_W + 2));
    assign rd_idx      = fetch.pc[ADDR_W+1:2];
    assign accept      = fetch.order && !load_en && (state == S_IDLE);
    assign load_rise   = load_en && !load_en_q;
    // A fresh session restarts at word 0 even if the counter still shows full.
    assign wr_full     = !load_rise && load_cnt[ADDR_W];
    assign wr_idx      = load_rise ? '0 : load_cnt[ADDR_W-1:0];
    assign go_resp     = ((state == S_READ) && (WAIT_CYCLES == 0)) ||
                         ((state == S_WAIT) && (wait_cnt == 4'd0));
    assign fetch.busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (load_en && load_we && !wr_full)
            mem[wr_idx] <= load_data;
        if (accept)
            rdata <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wait_cnt      <= 4'd0;
            bad_q         <= 1'b0;
            load_en_q     <= 1'b0;
            fetch.inst    <= '0;
            fetch.fetched <= 1'b0;
            misalign      <= 1'b0;
            overlap_err   <= 1'b0;
            load_cnt      <= '0;
            load_ovf      <= 1'b0;
        end else begin
            load_en_q     <= load_en;
            fetch.fetched <= go_resp;
            if (go_resp)
                fetch.inst <= bad_q ? '0 : rdata;

            if (fetch.order && !accept)
                overlap_err <= 1'b1;

            case (state)
                S_IDLE: if (accept) begin
                    bad_q <= pc_misalign || pc_range;
                    if (pc_misalign)
                        misalign <= 1'b1;
                    state <= S_READ;
                end
                S_READ: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= S_RESP;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase

            if (load_rise)
                load_cnt <= {{ADDR_W{1'b0}}, load_we};
            else if (load_en && load_we) begin
                if (load_cnt[ADDR_W])
                    load_ovf <= 1'b1;
                else
                    load_cnt <= load_cnt + 1'b1;
            end
        end
    end
endmodule
